// File: rtl/vending_pkg.sv
// -----------------------------------------------------------------------------
// vending_pkg
//   Shared types and constants for the vending front-end.
//   - state_e            : credit collector FSM states
//   - ITEM_NONE/1/2/3    : item codes presented to the vending FSM
//   - COIN_1/2/5/10      : coin denominations, 5 bits wide so that
//                          credit + coin never wraps before the overflow check
//   - DEFAULT_MAX_CREDIT : default credit ceiling (fits in the 4-bit credit)
// -----------------------------------------------------------------------------
package vending_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_REQUEST = 3'd2,
      ST_WAIT    = 3'd3,
      ST_REFUND  = 3'd4
   } state_e;

   localparam logic [1:0] ITEM_NONE = 2'b00;
   localparam logic [1:0] ITEM1     = 2'b01;
   localparam logic [1:0] ITEM2     = 2'b10;
   localparam logic [1:0] ITEM3     = 2'b11;

   localparam int COIN_VAL_W = 5;
   localparam int CREDIT_W   = 4;

   localparam logic [COIN_VAL_W-1:0] COIN_1  = 5'd1;
   localparam logic [COIN_VAL_W-1:0] COIN_2  = 5'd2;
   localparam logic [COIN_VAL_W-1:0] COIN_5  = 5'd5;
   localparam logic [COIN_VAL_W-1:0] COIN_10 = 5'd10;

   localparam int DEFAULT_MAX_CREDIT = 15;

endpackage : vending_pkg

// File: rtl/coin_decoder.sv
// -----------------------------------------------------------------------------
// coin_decoder
//   Maps the 2-bit coin type to its value in credit units. Denominations live
//   here only, so they can change without touching the collector FSM.
//   Ports:
//     coin_type  in  2  00 = 1, 01 = 2, 10 = 5, 11 = 10 units
//     coin_value out 5  decoded value, already widened for the credit adder
// -----------------------------------------------------------------------------
module coin_decoder
   import vending_pkg::*;
(
   input  logic [1:0]            coin_type,
   output logic [COIN_VAL_W-1:0] coin_value
);

   always_comb begin
      coin_value = COIN_1;
      unique case (coin_type)
         2'b00:   coin_value = COIN_1;
         2'b01:   coin_value = COIN_2;
         2'b10:   coin_value = COIN_5;
         2'b11:   coin_value = COIN_10;
         default: coin_value = COIN_1;
      endcase
   end

endmodule : coin_decoder

// File: rtl/coin_credit_collector.sv
// -----------------------------------------------------------------------------
// coin_credit_collector
//   Front-end of the vending datapath. Accumulates coin credit, turns a
//   product selection into a one-cycle item request for the vending FSM,
//   freezes money while that FSM decides, and handles cancel/refund.
//
//   Optional feature: define COIN_TIMEOUT_EN to auto-refund after
//   TIMEOUT_CYCLES idle cycles in COLLECT. Without it credit is held forever.
//
//   Parameters:
//     MAX_CREDIT      credit ceiling (<= 15); coins that would exceed it bounce
//     TIMEOUT_CYCLES  idle COLLECT cycles before auto-refund (COIN_TIMEOUT_EN)
//   Ports:
//     clk           in   1  system clock, rising edge
//     rst           in   1  synchronous active-high reset
//     coin_valid    in   1  one-cycle coin strobe
//     coin_type     in   2  coin denomination code
//     sel_valid     in   1  one-cycle selection strobe
//     sel           in   2  item code, 00 ignored
//     cancel        in   1  refund request
//     vend_ok       in   1  downstream dispensed
//     vend_fail     in   1  downstream insufficient funds
//     money         out  4  current credit
//     item          out  2  item code, non-zero for the single REQUEST cycle
//     busy          out  1  high in REQUEST and WAIT
//     coin_reject   out  1  one-cycle pulse when a coin is refused
//     refund_valid  out  1  one-cycle refund pulse
//     refund        out  4  refunded amount while refund_valid, else 0
// -----------------------------------------------------------------------------
module coin_credit_collector
   import vending_pkg::*;
#(
   parameter int MAX_CREDIT     = DEFAULT_MAX_CREDIT,
   parameter int TIMEOUT_CYCLES = 1000
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                coin_valid,
   input  logic [1:0]          coin_type,
   input  logic                sel_valid,
   input  logic [1:0]          sel,
   input  logic                cancel,
   input  logic                vend_ok,
   input  logic                vend_fail,
   output logic [CREDIT_W-1:0] money,
   output logic [1:0]          item,
   output logic                busy,
   output logic                coin_reject,
   output logic                refund_valid,
   output logic [CREDIT_W-1:0] refund
);

   localparam logic [COIN_VAL_W-1:0] MAX_SUM = COIN_VAL_W'(MAX_CREDIT);

   state_e                state_q, state_d;
   logic [CREDIT_W-1:0]   credit_q, credit_d;
   logic [1:0]            sel_q, sel_d;
   logic                  coin_reject_q, coin_reject_d;
   logic                  refund_valid_q, refund_valid_d;
   logic [CREDIT_W-1:0]   refund_q, refund_d;

   logic [COIN_VAL_W-1:0] coin_value;
   logic [COIN_VAL_W-1:0] coin_sum;
   logic                  coin_fits;
   logic                  sel_ok;
   logic                  timeout_hit;

   coin_decoder u_coin_decoder (
      .coin_type  (coin_type),
      .coin_value (coin_value)
   );

   // Sum is one bit wider than credit so an overflowing coin is detected
   // instead of wrapping.
   assign coin_sum  = {1'b0, credit_q} + coin_value;
   assign coin_fits = (coin_sum <= MAX_SUM);
   assign sel_ok    = sel_valid && (sel != ITEM_NONE);

`ifdef COIN_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d, idle_cnt_inc;
   logic             activity;

   // Counts idle COLLECT cycles. Held at zero outside COLLECT, which covers
   // the clear on vend_fail (WAIT -> COLLECT) and on the first coin.
   always_comb begin
      activity     = coin_valid || sel_ok;
      idle_cnt_inc = idle_cnt_q + CNT_W'(1);
      idle_cnt_d   = '0;
      timeout_hit  = 1'b0;
      if ((state_q == ST_COLLECT) && !activity) begin
         if (idle_cnt_inc == TIMEOUT_VAL) begin
            timeout_hit = 1'b1;
         end else begin
            idle_cnt_d = idle_cnt_inc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt_q <= '0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
      end
   end
`else
   localparam int timeout_unused = TIMEOUT_CYCLES;
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d        = state_q;
      credit_d       = credit_q;
      sel_d          = sel_q;
      coin_reject_d  = 1'b0;
      refund_valid_d = 1'b0;
      refund_d       = '0;

      unique case (state_q)
         ST_IDLE: begin
            // Selection and cancel mean nothing without credit.
            if (coin_valid) begin
               if (coin_fits) begin
                  credit_d = coin_sum[CREDIT_W-1:0];
                  state_d  = ST_COLLECT;
               end else begin
                  coin_reject_d = 1'b1;
               end
            end
         end

         ST_COLLECT: begin
            // Cancel (or timeout) beats a coin in the same cycle: the coin
            // bounces and the refund is the credit held before it.
            if (cancel || timeout_hit) begin
               refund_valid_d = 1'b1;
               refund_d       = credit_q;
               credit_d       = '0;
               coin_reject_d  = coin_valid;
               state_d        = ST_REFUND;
            end else begin
               if (coin_valid) begin
                  if (coin_fits) begin
                     credit_d = coin_sum[CREDIT_W-1:0];
                  end else begin
                     coin_reject_d = 1'b1;
                  end
               end
               // A coin in the same cycle still lands, so REQUEST shows the
               // summed credit.
               if (sel_ok) begin
                  sel_d   = sel;
                  state_d = ST_REQUEST;
               end
            end
         end

         ST_REQUEST: begin
            coin_reject_d = coin_valid;
            state_d       = ST_WAIT;
         end

         ST_WAIT: begin
            coin_reject_d = coin_valid;
            // vend_ok wins over vend_fail; change is handled downstream.
            if (vend_ok) begin
               credit_d = '0;
               state_d  = ST_IDLE;
            end else if (vend_fail) begin
               state_d = ST_COLLECT;
            end
         end

         ST_REFUND: begin
            coin_reject_d = coin_valid;
            state_d       = ST_IDLE;
         end

         default: begin
            credit_d = '0;
            state_d  = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         credit_q       <= '0;
         sel_q          <= ITEM_NONE;
         coin_reject_q  <= 1'b0;
         refund_valid_q <= 1'b0;
         refund_q       <= '0;
      end else begin
         state_q        <= state_d;
         credit_q       <= credit_d;
         sel_q          <= sel_d;
         coin_reject_q  <= coin_reject_d;
         refund_valid_q <= refund_valid_d;
         refund_q       <= refund_d;
      end
   end

   assign money        = credit_q;
   assign item         = (state_q == ST_REQUEST) ? sel_q : ITEM_NONE;
   assign busy         = (state_q == ST_REQUEST) || (state_q == ST_WAIT);
   assign coin_reject  = coin_reject_q;
   assign refund_valid = refund_valid_q;
   assign refund       = refund_q;

endmodule : coin_credit_collector

// File: tb/tb_coin_credit_collector.sv
// -----------------------------------------------------------------------------
// tb_coin_credit_collector
//   Directed scenarios followed by random traffic, every cycle compared with
//   a behavioural model of the collector kept in plain integers.
// -----------------------------------------------------------------------------
module tb_coin_credit_collector;

   localparam int MAXC = 15;
   localparam int TO   = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       coin_valid;
   logic [1:0] coin_type;
   logic       sel_valid;
   logic [1:0] sel;
   logic       cancel;
   logic       vend_ok;
   logic       vend_fail;
   logic [3:0] money;
   logic [1:0] item;
   logic       busy;
   logic       coin_reject;
   logic       refund_valid;
   logic [3:0] refund;

   int checks = 0;
   int errors = 0;

   // Behavioural model: credit as a number plus flags for the short-lived
   // phases (request cycle, waiting on the vend FSM, refund cycle).
   int m_credit = 0;
   int m_item   = 0;
   int m_amt    = 0;
   int m_idle   = 0;
   bit m_req    = 0;
   bit m_wait   = 0;
   bit m_pulse  = 0;
   bit m_reject = 0;

   always #5 clk = ~clk;

   coin_credit_collector #(
      .MAX_CREDIT     (MAXC),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .coin_valid   (coin_valid),
      .coin_type    (coin_type),
      .sel_valid    (sel_valid),
      .sel          (sel),
      .cancel       (cancel),
      .vend_ok      (vend_ok),
      .vend_fail    (vend_fail),
      .money        (money),
      .item         (item),
      .busy         (busy),
      .coin_reject  (coin_reject),
      .refund_valid (refund_valid),
      .refund       (refund)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input int exp);
      checks++;
      assert (obs === 8'(exp)) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int coin_val(input logic [1:0] t);
      case (t)
         2'b00:   return 1;
         2'b01:   return 2;
         2'b10:   return 5;
         default: return 10;
      endcase
   endfunction

   task automatic model_edge(input bit r, input bit cv, input logic [1:0] ct,
                             input bit sv, input logic [1:0] s, input bit can,
                             input bit ok, input bit fail);
      bit rej        = 0;
      bit pulse      = 0;
      int amt        = 0;
      bit selok      = sv && (s != 2'b00);
      int v          = coin_val(ct);
      bit was_refund = m_pulse;
      bit to         = 0;
      if (r) begin
         m_credit = 0; m_req = 0; m_wait = 0; m_item = 0; m_idle = 0;
      end else if (m_req) begin
         m_req = 0; m_wait = 1; rej = cv;
      end else if (m_wait) begin
         rej = cv;
         if (ok) begin
            m_credit = 0; m_wait = 0;
         end else if (fail) begin
            m_wait = 0; m_idle = 0;
         end
      end else if (was_refund) begin
         rej = cv;
      end else if (m_credit == 0) begin
         if (cv) begin
            if (v <= MAXC) begin
               m_credit = v; m_idle = 0;
            end else begin
               rej = 1;
            end
         end
      end else begin
`ifdef COIN_TIMEOUT_EN
         to = !(cv || selok) && (m_idle + 1 == TO);
`endif
         if (can || to) begin
            pulse = 1; amt = m_credit; m_credit = 0; rej = cv;
         end else begin
            if (cv) begin
               if (m_credit + v <= MAXC) m_credit = m_credit + v;
               else rej = 1;
            end
            if (selok) begin
               m_item = int'(s); m_req = 1;
            end
            m_idle = (cv || selok) ? 0 : m_idle + 1;
         end
      end
      m_reject = rej;
      m_pulse  = pulse;
      m_amt    = amt;
   endtask

   task automatic check_outputs();
      chk("money",        money,        m_credit);
      chk("item",         item,         m_req ? m_item : 0);
      chk("busy",         busy,         int'(m_req | m_wait));
      chk("coin_reject",  coin_reject,  int'(m_reject));
      chk("refund_valid", refund_valid, int'(m_pulse));
      chk("refund",       refund,       m_pulse ? m_amt : 0);
   endtask

   task automatic cyc(input bit r, input bit cv, input logic [1:0] ct,
                      input bit sv, input logic [1:0] s, input bit can,
                      input bit ok, input bit fail);
      rst = r; coin_valid = cv; coin_type = ct; sel_valid = sv; sel = s;
      cancel = can; vend_ok = ok; vend_fail = fail;
      model_edge(r, cv, ct, sv, s, can, ok, fail);
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic idle();
      cyc(0, 0, 2'b00, 0, 2'b00, 0, 0, 0);
   endtask

   task automatic coin(input logic [1:0] t);
      cyc(0, 1, t, 0, 2'b00, 0, 0, 0);
   endtask

   task automatic pick(input logic [1:0] s);
      cyc(0, 0, 2'b00, 1, s, 0, 0, 0);
   endtask

   initial begin
      rst = 1; coin_valid = 0; coin_type = 0; sel_valid = 0; sel = 0;
      cancel = 0; vend_ok = 0; vend_fail = 0;

      // Reset state
      cyc(1, 0, 2'b00, 0, 2'b00, 0, 0, 0);
      cyc(1, 0, 2'b00, 0, 2'b00, 0, 0, 0);
      chk("rst_money", money, 0);
      chk("rst_busy", busy, 0);
      idle();

      // Coins 2 + 5, select item1, vend_ok three cycles after the select
      coin(2'b01);
      coin(2'b10);
      pick(2'b01);
      chk("tp1_money_req", money, 7);
      chk("tp1_item_req", item, 1);
      chk("tp1_busy_req", busy, 1);
      idle();
      chk("tp1_item_wait", item, 0);
      idle();
      cyc(0, 0, 2'b00, 0, 2'b00, 0, 1, 0);
      chk("tp1_money_done", money, 0);
      chk("tp1_busy_done", busy, 0);

      // Overflow coin bounces, smaller coin still fits up to 15
      coin(2'b11);
      coin(2'b11);
      chk("tp2_reject", coin_reject, 1);
      chk("tp2_money_kept", money, 10);
      coin(2'b10);
      chk("tp2_money_15", money, 15);
      cyc(0, 0, 2'b00, 0, 2'b00, 1, 0, 0);
      chk("tp2_refund", refund, 15);
      idle();

      // vend_fail returns to COLLECT with credit kept, then cancel refunds it
      coin(2'b00);
      coin(2'b01);
      pick(2'b10);
      cyc(0, 1, 2'b00, 0, 2'b00, 0, 0, 0);
      chk("tp3_wait_coin_reject", coin_reject, 1);
      cyc(0, 0, 2'b00, 0, 2'b00, 0, 0, 1);
      chk("tp3_money_fail", money, 3);
      chk("tp3_busy_fail", busy, 0);
      cyc(0, 0, 2'b00, 0, 2'b00, 1, 0, 0);
      chk("tp3_refund_valid", refund_valid, 1);
      chk("tp3_refund", refund, 3);
      idle();
      chk("tp3_refund_gone", refund_valid, 0);

      // Coin and cancel together: coin bounces, refund is the old credit
      coin(2'b01);
      coin(2'b01);
      cyc(0, 1, 2'b00, 0, 2'b00, 1, 0, 0);
      chk("tp4_reject", coin_reject, 1);
      chk("tp4_refund", refund, 4);
      idle();

      // Reset while waiting discards credit silently
      coin(2'b10);
      coin(2'b01);
      coin(2'b01);
      pick(2'b11);
      idle();
      cyc(1, 0, 2'b00, 0, 2'b00, 0, 0, 0);
      chk("tp5_money", money, 0);
      chk("tp5_refund_valid", refund_valid, 0);
      idle();

      // Coin and selection together, then simultaneous ok/fail
      coin(2'b01);
      coin(2'b00);
      cyc(0, 1, 2'b10, 1, 2'b01, 0, 0, 0);
      chk("tp6_money_sum", money, 8);
      chk("tp6_item", item, 1);
      idle();
      cyc(0, 0, 2'b00, 0, 2'b00, 0, 1, 1);
      chk("tp6_ok_wins", money, 0);

`ifdef COIN_TIMEOUT_EN
      // Credit 6 left alone: refund exactly TO cycles after the last coin
      coin(2'b10);
      coin(2'b00);
      for (int i = 1; i < TO; i++) begin
         idle();
         chk("to_early", refund_valid, 0);
      end
      idle();
      chk("to_fire", refund_valid, 1);
      chk("to_amount", refund, 6);
      idle();
`else
      // Without the timeout credit is held indefinitely
      coin(2'b10);
      coin(2'b00);
      for (int i = 0; i < 20; i++) idle();
      chk("hold_money", money, 6);
      cyc(0, 0, 2'b00, 0, 2'b00, 1, 0, 0);
      idle();
`endif

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         cyc($urandom_range(0, 99) == 0,
             $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
             $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
             $urandom_range(0, 11) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_coin_credit_collector

// File: doc/coin_credit_collector.md
# coin_credit_collector

Upstream front-end of the vending datapath. Accepts coin pulses and a product selection, accumulates a 4-bit credit, and presents `money` plus a one-cycle item code to the vending FSM. It holds `money` stable until that FSM reports dispense or insufficient funds. It also handles cancel and refund and rejects overflowing coins.

## Interface
Parameters:
- `MAX_CREDIT`, 15: saturation ceiling for credit; must be ≤ 15.
- `TIMEOUT_CYCLES`, 1000: idle cycles in COLLECT before auto-refund. Used only with `COIN_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `coin_valid`  in  1  one-cycle coin strobe.
- `coin_type`  in  2  coin value: 00 = 1, 01 = 2, 10 = 5, 11 = 10 units.
- `sel_valid`  in  1  one-cycle selection strobe.
- `sel`  in  2  item code: 01 = item1, 10 = item2, 11 = item3; 00 is ignored.
- `cancel`  in  1  refund request.
- `vend_ok`  in  1  downstream dispensed (its `out`).
- `vend_fail`  in  1  downstream insufficient funds (its `insufficient_money`).
- `money`  out  4  current credit, driven to the downstream `money`.
- `item`  out  2  item code to the downstream `in`; 00 except for one cycle per request.
- `busy`  out  1  high in REQUEST and WAIT.
- `coin_reject`  out  1  one-cycle pulse when a coin is refused.
- `refund_valid`  out  1  one-cycle pulse.
- `refund`  out  4  refunded amount; valid only while `refund_valid` is high, else 0.

## Operation
States:
- IDLE: credit = 0.
- COLLECT: credit > 0.
- REQUEST: single cycle.
- WAIT: awaiting vend result.
- REFUND: single cycle.

Coin handling:
- Coin value is widened to 5 bits and added to credit.
- If the sum is ≤ `MAX_CREDIT`: credit takes the sum. IDLE→COLLECT.
- Otherwise: credit is unchanged and `coin_reject` pulses.
- Coins arriving in REQUEST, WAIT or REFUND are rejected (`coin_reject` pulse).

Selection:
- In COLLECT, `sel_valid` with `sel` ≠ 00 latches `sel` and moves to REQUEST.
- Selection is ignored in IDLE and when `sel` = 00.

Request and wait:
- REQUEST: `item` = latched sel for exactly this cycle, then WAIT.
- WAIT, `vend_ok`: credit cleared, go to IDLE. Change is computed downstream.
- WAIT, `vend_fail`: credit kept, go to COLLECT; `item` returns to 00.
- `vend_ok` and `vend_fail` asserted together: `vend_ok` wins.

Cancel:
- In COLLECT: go to REFUND; `refund` = credit, `refund_valid` = 1, credit cleared, then IDLE.
- Ignored in IDLE, REQUEST and WAIT.

Same-cycle priority in COLLECT: cancel > coin > selection.
- Coin and selection together: both accepted. The summed credit is presented in REQUEST.
- Cancel and coin together: the coin is rejected; refund = old credit.

Reset:
- All outputs 0, credit 0, state IDLE.
- Reset mid-operation discards credit without a refund pulse.

## Timing
- `coin_valid` at edge n → `money` updated after edge n (visible cycle n+1).
- `sel_valid` at edge n → `item` valid and `busy` = 1 in cycle n+1. `money` is already stable in that cycle and stays frozen through WAIT.
- Downstream samples `item` at edge n+1 and reports in cycle n+2 or later. WAIT has no upper bound.
- `coin_reject` and `refund_valid` are registered: high for the cycle after the triggering edge.
- Back-to-back coins on consecutive cycles are all accepted. No dead cycles in COLLECT.

## Configuration
- `COIN_TIMEOUT_EN` defined:
  - A `$clog2(TIMEOUT_CYCLES+1)`-bit counter runs in COLLECT. It is cleared by any coin, selection or `vend_fail`.
  - Reaching `TIMEOUT_CYCLES` forces REFUND exactly as a cancel would.
- `COIN_TIMEOUT_EN` undefined: no counter; credit is held indefinitely.

## Structure
- Package `vending_pkg` holds:
  - state enum;
  - item codes `ITEM1/2/3`;
  - coin values `COIN_1/2/5/10`;
  - default `MAX_CREDIT`.
- Sub-module `coin_decoder`: `coin_type` → 5-bit value. Kept separate so coin denominations can change without touching the FSM.

## Test plan
- Coins 2 then 5, select 01, `vend_ok` in cycle 3 after select → `money` = 7, `item` = 01 for one cycle, credit returns to 0 in IDLE.
- Credit 10, insert 10-unit coin → `coin_reject` pulse, `money` stays 10; then insert 5 → `money` = 15.
- Credit 3, select 10, `vend_fail` → back to COLLECT with `money` = 3; `cancel` → `refund_valid` pulse with `refund` = 3, then IDLE.
- Coin and cancel in the same cycle with credit 4 → coin rejected, refund = 4.
- Reset asserted during WAIT with credit 9 → all outputs 0 next cycle, no refund pulse.
- With `COIN_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 8, credit 6, no activity → refund of 6 issued exactly 8 cycles after the last coin.
